// File: rtl/fft_cbfp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_cbfp_pkg
// Purpose  : Shared constants, types and the redundant-sign-bit helper for
//            the CBFP block-scaling controller.
// Revision : 1.0 - initial release
// ============================================================================
package fft_cbfp_pkg;

    localparam int c_lanes     = 16;
    localparam int c_beats     = 4;
    localparam int c_din_w     = 23;
    localparam int c_dout_w    = 16;
    localparam int c_max_shift = 12;
    localparam int c_rsb_w     = $clog2(c_din_w);
    localparam int c_shift_w   = $clog2(c_max_shift + 1);

    typedef logic signed [c_din_w-1:0]  din_t;
    typedef logic signed [c_dout_w-1:0] dout_t;
    typedef din_t  [c_lanes-1:0]        din_beat_t;
    typedef dout_t [c_lanes-1:0]        dout_beat_t;
    typedef logic [c_rsb_w-1:0]         rsb_t;
    typedef logic [c_shift_w-1:0]       shift_t;

    // Number of bits below the sign bit that still equal the sign bit.
    // 0 and -1 both give c_din_w-1.
    function automatic rsb_t rsb_f(din_t value);
        rsb_t cnt;
        logic run;
        cnt = '0;
        run = 1'b1;
        for (int i = c_din_w - 2; i >= 0; i--) begin
            if (run && (value[i] == value[c_din_w-1])) begin
                cnt = cnt + rsb_t'(1);
            end else begin
                run = 1'b0;
            end
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_cbfp_beat_min.sv
`default_nettype none
// ============================================================================
// Module   : fft_cbfp_beat_min
// Purpose  : Combinational minimum of the redundant-sign-bit count over all
//            2*LANES components of one beat.
// Ports    : din_re/din_im  flat LANES x DIN_W component vectors
//            min_rsb        minimum rsb over the beat
// Revision : 1.0 - initial release
// ============================================================================
module fft_cbfp_beat_min
    import fft_cbfp_pkg::*;
(
    input  logic [c_lanes*c_din_w-1:0] din_re,
    input  logic [c_lanes*c_din_w-1:0] din_im,
    output logic [c_rsb_w-1:0]         min_rsb
);

    rsb_t w_rsb [2*c_lanes];

    for (genvar i = 0; i < c_lanes; i++) begin : g_comp
        assign w_rsb[2*i]   = rsb_f(din_re[i*c_din_w +: c_din_w]);
        assign w_rsb[2*i+1] = rsb_f(din_im[i*c_din_w +: c_din_w]);
    end

    always_comb begin
        min_rsb = rsb_t'(c_din_w - 1);
        for (int k = 0; k < 2*c_lanes; k++) begin
            if (w_rsb[k] < min_rsb) begin
                min_rsb = w_rsb[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_cbfp_blk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fft_cbfp_blk_ctrl
// Purpose  : Convergent block-floating-point scaler. Buffers a block of BEATS
//            beats in a ping-pong buffer while tracking the minimum redundant
//            sign bit count, then replays the block shifted left by that
//            common exponent (saturated at MAX_SHIFT), truncated to DOUT_W.
// Ports    : clk, rstn (async, active-low)
//            in_valid/in_ready, din_re/din_im   input beat stream
//            out_valid/out_ready, dout_re/dout_im, out_shift, out_last
//            cfg_bypass (only with CBFP_BYPASS_EN) forces a block's shift to 0
// Options  : CBFP_BYPASS_EN - adds the cfg_bypass port.
// Revision : 1.0 - initial release
// ============================================================================
module fft_cbfp_blk_ctrl
    import fft_cbfp_pkg::*;
#(
    parameter int LANES     = c_lanes,
    parameter int BEATS     = c_beats,
    parameter int DIN_W     = c_din_w,
    parameter int DOUT_W    = c_dout_w,
    parameter int MAX_SHIFT = c_max_shift
) (
    input  logic                               clk,
    input  logic                               rstn,
`ifdef CBFP_BYPASS_EN
    input  logic                               cfg_bypass,
`endif
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [LANES*DIN_W-1:0]             din_re,
    input  logic [LANES*DIN_W-1:0]             din_im,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [LANES*DOUT_W-1:0]            dout_re,
    output logic [LANES*DOUT_W-1:0]            dout_im,
    output logic [$clog2(MAX_SHIFT+1)-1:0]     out_shift,
    output logic                               out_last
);

    localparam int c_cnt_w = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int c_sh_w  = $clog2(MAX_SHIFT + 1);
    localparam int c_rs_w  = $clog2(DIN_W);

    logic                     r_wr_bank;
    logic                     r_rd_bank;
    logic [c_cnt_w-1:0]       r_wr_cnt;
    logic [c_cnt_w-1:0]       r_rd_cnt;
    logic [1:0]               r_full;
    logic [c_rs_w-1:0]        r_run_min;
    logic [c_sh_w-1:0]        r_exp [2];
    logic [LANES*DIN_W-1:0]   r_buf_re [2][BEATS];
    logic [LANES*DIN_W-1:0]   r_buf_im [2][BEATS];

    logic [c_rs_w-1:0]        w_beat_rsb;
    logic [c_rs_w-1:0]        w_new_min;
    logic [c_sh_w-1:0]        w_blk_exp;
    logic [c_sh_w-1:0]        w_exp_store;
    logic                     w_wr_fire;
    logic                     w_wr_last;
    logic                     w_rd_fire;
    logic                     w_rd_last;
    logic [1:0]               w_full_nxt;
    logic [LANES*DIN_W-1:0]   w_rd_re;
    logic [LANES*DIN_W-1:0]   w_rd_im;

    fft_cbfp_beat_min u_beat_min (
        .din_re  (din_re),
        .din_im  (din_im),
        .min_rsb (w_beat_rsb)
    );

    assign in_ready  = !r_full[r_wr_bank];
    assign out_valid = r_full[r_rd_bank];
    assign out_shift = r_exp[r_rd_bank];
    assign out_last  = (r_rd_cnt == c_cnt_w'(BEATS - 1));

    assign w_wr_fire = in_valid && in_ready;
    assign w_wr_last = w_wr_fire && (r_wr_cnt == c_cnt_w'(BEATS - 1));
    assign w_rd_fire = out_valid && out_ready;
    assign w_rd_last = w_rd_fire && out_last;

    assign w_new_min = (w_beat_rsb < r_run_min) ? w_beat_rsb : r_run_min;
    assign w_blk_exp = (w_new_min > c_rs_w'(MAX_SHIFT)) ? c_sh_w'(MAX_SHIFT)
                                                        : c_sh_w'(w_new_min);
`ifdef CBFP_BYPASS_EN
    assign w_exp_store = cfg_bypass ? '0 : w_blk_exp;
`else
    assign w_exp_store = w_blk_exp;
`endif

    // A completing write and a completing read always target different banks
    // (write needs an empty bank, read needs a full one), so both apply.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_rd_last) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_full    <= '0;
            r_run_min <= c_rs_w'(DIN_W - 1);
            r_exp[0]  <= '0;
            r_exp[1]  <= '0;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr_fire) begin
                if (w_wr_last) begin
                    r_exp[r_wr_bank] <= w_exp_store;
                    r_wr_bank        <= ~r_wr_bank;
                    r_wr_cnt         <= '0;
                    r_run_min        <= c_rs_w'(DIN_W - 1);
                end else begin
                    r_wr_cnt  <= r_wr_cnt + c_cnt_w'(1);
                    r_run_min <= w_new_min;
                end
            end
            if (w_rd_fire) begin
                if (w_rd_last) begin
                    r_rd_bank <= ~r_rd_bank;
                    r_rd_cnt  <= '0;
                end else begin
                    r_rd_cnt <= r_rd_cnt + c_cnt_w'(1);
                end
            end
        end
    end

    // Sample storage carries no reset; contents only matter once a bank is full.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_buf_re[r_wr_bank][r_wr_cnt] <= din_re;
            r_buf_im[r_wr_bank][r_wr_cnt] <= din_im;
        end
    end

    assign w_rd_re = r_buf_re[r_rd_bank][r_rd_cnt];
    assign w_rd_im = r_buf_im[r_rd_bank][r_rd_cnt];

    // The shift never exceeds the block's rsb, so the bits dropped above the
    // output window are all sign copies and no overflow can occur.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [DIN_W-1:0] w_sh_re;
        logic signed [DIN_W-1:0] w_sh_im;
        assign w_sh_re = $signed(w_rd_re[i*DIN_W +: DIN_W]) <<< out_shift;
        assign w_sh_im = $signed(w_rd_im[i*DIN_W +: DIN_W]) <<< out_shift;
        assign dout_re[i*DOUT_W +: DOUT_W] = out_valid ? w_sh_re[DIN_W-1 -: DOUT_W] : '0;
        assign dout_im[i*DOUT_W +: DOUT_W] = out_valid ? w_sh_im[DIN_W-1 -: DOUT_W] : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_cbfp_blk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_cbfp_blk_ctrl
// Purpose  : Directed self-checking bench for fft_cbfp_blk_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_cbfp_blk_ctrl;

    localparam int LANES  = 16;
    localparam int BEATS  = 4;
    localparam int DIN_W  = 23;
    localparam int DOUT_W = 16;
    localparam int SP_LN  = 5;

    logic                       clk = 1'b0;
    logic                       rstn = 1'b0;
    logic                       in_valid = 1'b0;
    logic                       in_ready;
    logic [LANES*DIN_W-1:0]     din_re = '0;
    logic [LANES*DIN_W-1:0]     din_im = '0;
    logic                       out_valid;
    logic                       out_ready = 1'b0;
    logic [LANES*DOUT_W-1:0]    dout_re;
    logic [LANES*DOUT_W-1:0]    dout_im;
    logic [3:0]                 out_shift;
    logic                       out_last;
`ifdef CBFP_BYPASS_EN
    logic                       cfg_bypass = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    fft_cbfp_blk_ctrl u_dut (
        .clk       (clk),
        .rstn      (rstn),
`ifdef CBFP_BYPASS_EN
        .cfg_bypass(cfg_bypass),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din_re    (din_re),
        .din_im    (din_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout_re   (dout_re),
        .dout_im   (dout_im),
        .out_shift (out_shift),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LANES*DIN_W-1:0] rep_in(input logic [DIN_W-1:0] v);
        logic [LANES*DIN_W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*DIN_W +: DIN_W] = v;
        return r;
    endfunction

    function automatic logic [LANES*DOUT_W-1:0] rep_out(input logic [DOUT_W-1:0] v);
        logic [LANES*DOUT_W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*DOUT_W +: DOUT_W] = v;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat and returns one step after the accepting edge.
    task automatic send_beat(input logic [LANES*DIN_W-1:0] re, input logic [LANES*DIN_W-1:0] im);
        int n = 0;
        din_re   = re;
        din_im   = im;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("in_ready_wait", in_ready, 1'b1);
        tick();
    endtask

    // sp_beat < 0 means no special component; otherwise lane SP_LN real part
    // of that beat carries sp_val.
    task automatic send_block(input logic [DIN_W-1:0] v, input int sp_beat, input logic [DIN_W-1:0] sp_val);
        logic [LANES*DIN_W-1:0] re;
        for (int b = 0; b < BEATS; b++) begin
            re = rep_in(v);
            if (b == sp_beat) re[SP_LN*DIN_W +: DIN_W] = sp_val;
            send_beat(re, rep_in(v));
        end
        in_valid = 1'b0;
    endtask

    task automatic recv_block(input string tag, input logic [3:0] sh, input logic [DOUT_W-1:0] ov,
                              input int sp_beat, input logic [DOUT_W-1:0] sp_out);
        logic [LANES*DOUT_W-1:0] ere;
        int n;
        out_ready = 1'b1;
        for (int b = 0; b < BEATS; b++) begin
            n = 0;
            while (!out_valid && n < 100) begin
                tick();
                n++;
            end
            ere = rep_out(ov);
            if (b == sp_beat) ere[SP_LN*DOUT_W +: DOUT_W] = sp_out;
            check($sformatf("%s_b%0d_valid", tag, b), out_valid, 1'b1);
            check($sformatf("%s_b%0d_shift", tag, b), out_shift, sh);
            check($sformatf("%s_b%0d_last", tag, b), out_last, (b == BEATS-1));
            check($sformatf("%s_b%0d_re", tag, b), dout_re, ere);
            check($sformatf("%s_b%0d_im", tag, b), dout_im, rep_out(ov));
            tick();
        end
    endtask

    initial begin
        #12;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_shift", out_shift, 4'd0);
        check("rst_dout_re", dout_re, '0);
        rstn = 1'b1;
        tick();

        // Single block of 256s: latency, shift 12, 0x2000 outputs.
        out_ready = 1'b1;
        for (int b = 0; b < BEATS - 1; b++) send_beat(rep_in(23'd256), rep_in(23'd256));
        check("t1_valid_early", out_valid, 1'b0);
        send_beat(rep_in(23'd256), rep_in(23'd256));
        in_valid = 1'b0;
        check("t1_valid_latency", out_valid, 1'b1);
        recv_block("t1", 4'd12, 16'h2000, -1, 16'h0);

        // Full-scale negative component forces shift 0.
        send_block(23'd256, 2, 23'h400000);
        recv_block("t2", 4'd0, 16'h0002, 2, 16'h8000);

        // All-zero block saturates the shift.
        send_block(23'd0, -1, 23'd0);
        recv_block("t3", 4'd12, 16'h0000, -1, 16'h0);

        // Back-pressure with continuous input.
        fork
            begin
                send_block(23'd256, -1, 23'd0);
                send_block(23'd256, 2, 23'h400000);
                send_block(23'd0, -1, 23'd0);
            end
            begin
                out_ready = 1'b0;
                repeat (7) tick();
                check("bp_ready_7", in_ready, 1'b1);
                tick();
                check("bp_ready_8", in_ready, 1'b0);
                repeat (4) tick();
                check("bp_ready_12", in_ready, 1'b0);
                recv_block("bpA", 4'd12, 16'h2000, -1, 16'h0);
                recv_block("bpB", 4'd0, 16'h0002, 2, 16'h8000);
                recv_block("bpC", 4'd12, 16'h0000, -1, 16'h0);
            end
        join
        check("bp_drained", out_valid, 1'b0);

        // Reset with a full bank pending and a partial block in flight.
        out_ready = 1'b0;
        send_block(23'd256, -1, 23'd0);
        send_beat(rep_in(23'h400000), rep_in(23'd0));
        send_beat(rep_in(23'h400000), rep_in(23'd0));
        in_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check("rst2_out_valid", out_valid, 1'b0);
        check("rst2_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #3;
        rstn = 1'b1;
        tick();
        send_block(23'd256, -1, 23'd0);
        recv_block("t5", 4'd12, 16'h2000, -1, 16'h0);
        check("t5_no_leftover", out_valid, 1'b0);

`ifdef CBFP_BYPASS_EN
        cfg_bypass = 1'b1;
        send_block(23'd256, -1, 23'd0);
        cfg_bypass = 1'b0;
        recv_block("byp", 4'd0, 16'h0002, -1, 16'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_cbfp_blk_ctrl.md
Name: fft_cbfp_blk_ctrl

Overview:
- Convergent block-floating-point (CBFP) scaling controller for one FFT stage output.
- Collects one block of BEATS input beats (LANES complex samples per beat) into a ping-pong buffer and tracks the minimum redundant-sign-bit count over the block.
- When the block is complete, replays it left-shifted by that common exponent, truncated to DOUT_W.
- Emits each block's shift value alongside the data, for the downstream exponent-index tracker.

Parameters:
- LANES, 16, complex samples per beat.
- BEATS, 4, beats per CBFP block (block = LANES*BEATS samples).
- DIN_W, 23, signed input width per re/im component.
- DOUT_W, 16, signed output width per component (DOUT_W <= DIN_W).
- MAX_SHIFT, 12, saturation limit of the block shift.

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  controller can accept a beat
- din_re  in  LANES x DIN_W signed  real parts
- din_im  in  LANES x DIN_W signed  imaginary parts
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- dout_re  out  LANES x DOUT_W signed  scaled real parts
- dout_im  out  LANES x DOUT_W signed  scaled imaginary parts
- out_shift  out  $clog2(MAX_SHIFT+1)  shift applied to current block
- out_last  out  1  last beat of block

Behaviour:
- Clock clk; reset rstn, asynchronous, active-low.
- Reset state: wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, full[1:0]=0, running min=DIN_W-1, both bank exponents=0.
- Reset outputs: in_ready=1, out_valid=0, out_last=0, out_shift=0, dout=0 (forced while !out_valid).
- Buffer contents are don't-care after reset. Reset mid-block discards all partial and complete blocks.
- Redundant sign bits of value x (rsb): count of leading bits equal to x[DIN_W-1], minus 1. Range 0..DIN_W-1; 0 and -1 give DIN_W-1.
- Beat rsb = min over all 2*LANES components of the beat; computed combinationally.
- Write side, per accepted beat (in_valid && in_ready):
  - Store beat in buffer[wr_bank][wr_cnt].
  - Update running min = min(running min, beat rsb).
  - wr_cnt increments.
- Last write beat (wr_cnt==BEATS-1):
  - exp[wr_bank] <= min(final min, MAX_SHIFT).
  - full[wr_bank] <= 1; wr_bank toggles; wr_cnt <= 0; running min <= DIN_W-1.
- in_ready = !full[wr_bank]. A full bank is never overwritten.
- Read side:
  - out_valid = full[rd_bank]; out_shift = exp[rd_bank]; out_last = (rd_cnt==BEATS-1).
  - dout component = (buffer[rd_bank][rd_cnt] <<< out_shift)[DIN_W-1 -: DOUT_W]. No rounding; no overflow is possible by construction of rsb.
- Per accepted output beat (out_valid && out_ready): rd_cnt increments.
- Last read beat: full[rd_bank] <= 0, rd_bank toggles, rd_cnt <= 0.
- Latency: out_valid is high in the cycle after the handshake of a block's last input beat; zero-bubble streaming when out_ready=1.
- Same-cycle write completion and read completion: both take effect independently (different banks).
- With both banks full: in_ready=0. It returns to 1 the cycle after the last read beat of the older block.
- Throughput: one beat/cycle sustained when out_ready is held high.

Optional Feature:
- CBFP_BYPASS_EN defined: adds input port cfg_bypass (1 bit, sampled per block at last write beat). When set, that block's stored exp is 0 regardless of rsb; data passes as the top DOUT_W bits unshifted.
- Macro undefined: no port, normal scaling only.

Decomposition:
- Package fft_cbfp_pkg: typedefs for beat arrays (re/im of LANES x DIN_W, LANES x DOUT_W), shift type width, function rsb_f(value).
- Sub-module fft_cbfp_beat_min: combinational min-rsb tree over 2*LANES components, instantiated once in the controller.

Test Plan:
- Single block, all components 256: out_shift=12, every dout=0x2000, out_valid first high 1 cycle after 4th input beat, out_last on beat 3.
- Block with one component = -4194304 in beat 2, others 256: out_shift=0, that output=-32768, other outputs=2.
- All-zero block: out_shift=12 (saturated), all outputs 0.
- out_ready=0 for 12 cycles, in_valid=1 continuously: in_ready falls after 8 accepted beats; after out_ready=1, blocks emerge in order with correct per-block shifts and no loss.
- Assert rstn=0 after 2 beats of a block with a full bank pending: out_valid=0 and in_ready=1 immediately; the next 4 beats form a fresh block.
- With CBFP_BYPASS_EN, cfg_bypass=1 and the 256 pattern: out_shift=0, dout=2.
